// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the EX stage (master) and the mdu_hilo engine (slave).
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, mthi, mtlo, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, mthi, mtlo, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply/divide engine owning the HI/LO registers.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 1xx).
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       resetn,
  mdu_hilo_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;          // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   mag_a, mag_b, a_raw, hi_q, lo_q;
  logic               is_div_q, neg_res, neg_rem, b_zero, div_zero_q;
`ifdef MDU_MADD_EN
  logic               madd_q, msub_q;
`endif

  logic op_legal, op_signed, sign_a, sign_b, is_div_in, accept;

`ifdef MDU_MADD_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = ~bus.op[2];
`endif
  assign op_signed = ~bus.op[0];
  assign sign_a    = op_signed & bus.a[WIDTH-1];
  assign sign_b    = op_signed & bus.b[WIDTH-1];
  assign is_div_in = ~bus.op[2] & bus.op[1];
  // A flushed instruction must not start the engine, so cancel masks start.
  assign accept    = bus.start & op_legal & ~bus.cancel & (state != S_BUSY);

  logic [WIDTH-1:0]   addend, quo, rem, hi_res, lo_res;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] acc_next, prod;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    addend   = acc[0] ? mag_a : {WIDTH{1'b0}};
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end

    prod = neg_res ? -acc_next : acc_next;
    quo  = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem  = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];

    if (is_div_q) begin
      // Most-negative / -1 needs no special case: |a| = 2^(W-1), q wraps back.
      hi_res = b_zero ? a_raw : rem;
      lo_res = b_zero ? {WIDTH{1'b1}} : quo;
    end else begin
      {hi_res, lo_res} = prod;
`ifdef MDU_MADD_EN
      if (madd_q) {hi_res, lo_res} = msub_q ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: datapath registers are reset too so nothing downstream ever sees X.
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      mag_a      <= '0;
      mag_b      <= '0;
      a_raw      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      b_zero     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MDU_MADD_EN
      madd_q     <= 1'b0;
      msub_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      div_zero_q <= 1'b0;
      case (state)
        S_BUSY: begin
          if (bus.cancel) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              hi_q       <= hi_res;
              lo_q       <= lo_res;
              div_zero_q <= is_div_q & b_zero;
              state      <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          if (accept) begin
            state    <= S_BUSY;
            cnt      <= '0;
            mag_a    <= sign_a ? -bus.a : bus.a;
            mag_b    <= sign_b ? -bus.b : bus.b;
            a_raw    <= bus.a;
            is_div_q <= is_div_in;
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            b_zero   <= (bus.b == '0);
            acc      <= {{WIDTH{1'b0}}, (is_div_in ? (sign_a ? -bus.a : bus.a)
                                                   : (sign_b ? -bus.b : bus.b))};
`ifdef MDU_MADD_EN
            madd_q   <= bus.op[2];
            msub_q   <= bus.op[1];
`endif
          end
        end
      endcase

      // MTHI/MTLO are only honoured outside BUSY, so they never race the finish write.
      if (state != S_BUSY) begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy     = (state == S_BUSY);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vector table, handshake corner cases,
// and randomized operations against an arithmetic reference model.
module tb_mdu_hilo;
  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mdu_hilo_if #(.WIDTH(WIDTH)) bus ();
  mdu_hilo #(.WIDTH(WIDTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the architectural values.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, y, h_in, l_in,
                                output logic [31:0] h, l, output logic dz);
    int sx, sy;
    longint sp;
    logic [63:0] p;
    sx = x; sy = y; dz = 1'b0; h = h_in; l = l_in; p = '0;
    if (o[2:1] == 2'b01) begin
      if (y == 0) begin
        h = x; l = '1; dz = 1'b1;
      end else if (!o[0]) begin
        if (x == 32'h8000_0000 && y == 32'hffff_ffff) begin
          h = 32'h0; l = 32'h8000_0000;
        end else begin
          h = sx % sy; l = sx / sy;
        end
      end else begin
        h = x % y; l = x / y;
      end
    end else begin
      if (!o[0]) begin
        sp = longint'(sx) * longint'(sy);
        p = sp;
      end else begin
        p = {32'b0, x} * {32'b0, y};
      end
      if (o[2]) p = o[1] ? ({h_in, l_in} - p) : ({h_in, l_in} + p);
      {h, l} = p;
    end
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic mt_write(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk); bus.mthi = 1'b1; bus.wdata = h;
    @(negedge clk); bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = l;
    @(negedge clk); bus.mtlo = 1'b0;
  endtask

  // Called at the negedge of cycle 'first' after the accept edge; returns in the done cycle.
  task automatic wait_done(input int first, output int lat, output int busy_n,
                           output int overlap, output bit got);
    lat = 0; busy_n = 0; overlap = 0; got = 1'b0;
    for (int i = first; i <= first + 2 * WIDTH && !got; i++) begin
      lat = i;
      if (bus.busy) busy_n++;
      if (bus.busy && bus.done) overlap++;
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int lat, busy_n, overlap;
    bit got;
    logic [31:0] m_hi, m_lo, e_hi, e_lo;
    logic e_dz;
    logic [2:0] r_op;
    logic [31:0] r_a, r_b;

    vecs[0] = '{3'd0, 32'hffff_fffd, 32'd7,          32'hffff_ffff, 32'hffff_ffeb, 1'b0, "mult_neg"};
    vecs[1] = '{3'd2, 32'hffff_fff9, 32'd2,          32'hffff_ffff, 32'hffff_fffd, 1'b0, "div_neg"};
    vecs[2] = '{3'd2, 32'h8000_0000, 32'hffff_ffff,  32'h0,         32'h8000_0000, 1'b0, "div_ovf"};
    vecs[3] = '{3'd3, 32'd5,         32'd0,          32'd5,         32'hffff_ffff, 1'b1, "divu_zero"};
    vecs[4] = '{3'd1, 32'hffff_ffff, 32'hffff_ffff,  32'hffff_fffe, 32'h0000_0001, 1'b0, "multu_max"};
    vecs[5] = '{3'd2, 32'd7,         32'hffff_fffe,  32'd1,         32'hffff_fffd, 1'b0, "div_negdiv"};
    vecs[6] = '{3'd2, 32'hffff_fffb, 32'd0,          32'hffff_fffb, 32'hffff_ffff, 1'b1, "div_zero"};
    vecs[7] = '{3'd3, 32'hffff_ffff, 32'd10,         32'd5,         32'h1999_9999, 1'b0, "divu_big"};
    vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0,         1'b0, "mult_minmin"};
    vecs[9] = '{3'd1, 32'd0,         32'h1234_5678,  32'h0,         32'h0,         1'b0, "multu_zero"};

    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    bus.cancel = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;

    repeat (3) @(negedge clk);
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_dz", bus.div_zero, 0);
    resetn = 1'b1;

    // Directed vectors with latency and handshake checks.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, lat, busy_n, overlap, got);
      check({vecs[i].name, "_done"}, got, 1);
      check({vecs[i].name, "_lat"}, lat, LAT);
      check({vecs[i].name, "_busycnt"}, busy_n, WIDTH);
      check({vecs[i].name, "_overlap"}, overlap, 0);
      check({vecs[i].name, "_hi"}, bus.hi, vecs[i].hi);
      check({vecs[i].name, "_lo"}, bus.lo, vecs[i].lo);
      check({vecs[i].name, "_dz"}, bus.div_zero, vecs[i].dz);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, bus.done, 0);
      check({vecs[i].name, "_dz_pulse"}, bus.div_zero, 0);
    end

    // Cancel mid-BUSY: no done, HI/LO untouched.
    mt_write(32'h11, 32'h22);
    issue(3'd1, 32'hffff_ffff, 32'd3);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", bus.busy, 0);
    watch_no_done("cancel_nodone", 40);
    check("cancel_hi", bus.hi, 32'h11);
    check("cancel_lo", bus.lo, 32'h22);

    // Asynchronous reset in the middle of an operation.
    mt_write(32'haa, 32'hbb);
    issue(3'd0, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_mid_hi", bus.hi, 0);
    check("rst_mid_lo", bus.lo, 0);
    check("rst_mid_busy", bus.busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    watch_no_done("rst_mid_nodone", 40);

    // MTHI dropped while BUSY, then back-to-back start in the DONE cycle.
    mt_write(32'h1234_5678, 32'h9abc_def0);
    issue(3'd0, 32'd3, 32'd5);
    repeat (2) @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'hdead_beef;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi_busy_dropped", bus.hi, 32'h1234_5678);
    wait_done(4, lat, busy_n, overlap, got);
    check("b2b_first_done", got, 1);
    check("b2b_first_lat", lat, LAT);
    check("b2b_first_lo", bus.lo, 32'd15);
    check("b2b_first_hi", bus.hi, 32'd0);
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_no_gap", bus.busy, 1);
    wait_done(1, lat, busy_n, overlap, got);
    check("b2b_second_lat", lat, LAT);
    check("b2b_second_hi", bus.hi, 32'd2);
    check("b2b_second_lo", bus.lo, 32'd14);

    // MTLO in the DONE cycle overwrites the fresh result.
    bus.mtlo = 1'b1; bus.wdata = 32'h0000_cafe;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mtlo_done_lo", bus.lo, 32'h0000_cafe);
    check("mtlo_done_hi", bus.hi, 32'd2);

    // MTHI together with an accepted start: write lands, finish overwrites it.
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd6; bus.b = 32'd7;
    bus.mthi = 1'b1; bus.wdata = 32'h5555;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0;
    check("mthi_accept_hi", bus.hi, 32'h5555);
    check("mthi_accept_busy", bus.busy, 1);
    wait_done(1, lat, busy_n, overlap, got);
    check("mthi_accept_res_hi", bus.hi, 32'd0);
    check("mthi_accept_res_lo", bus.lo, 32'd42);

    // Randomized operations against the reference model.
    m_hi = $urandom;
    m_lo = $urandom;
    mt_write(m_hi, m_lo);
    for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
      r_op = 3'($urandom_range(0, 7));
`else
      r_op = 3'($urandom_range(0, 3));
`endif
      r_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = 32'hffff_ffff;
        2, 3:    r_b = 32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      model(r_op, r_a, r_b, m_hi, m_lo, e_hi, e_lo, e_dz);
      issue(r_op, r_a, r_b);
      wait_done(1, lat, busy_n, overlap, got);
      check("rand_done", got, 1);
      check("rand_hi", bus.hi, e_hi);
      check("rand_lo", bus.lo, e_lo);
      check("rand_dz", bus.div_zero, e_dz);
      m_hi = e_hi;
      m_lo = e_lo;
    end

    // MADDU accumulate, or ignored when the accumulate feature is absent.
    mt_write(32'h0, 32'h1);
    issue(3'd5, 32'hffff_ffff, 32'hffff_ffff);
`ifdef MDU_MADD_EN
    wait_done(1, lat, busy_n, overlap, got);
    check("maddu_done", got, 1);
    check("maddu_hi", bus.hi, 32'hffff_fffe);
    check("maddu_lo", bus.lo, 32'h0000_0002);
`else
    check("maddu_ignored_busy", bus.busy, 0);
    watch_no_done("maddu_ignored_nodone", 40);
    check("maddu_ignored_hi", bus.hi, 32'h0);
    check("maddu_ignored_lo", bus.lo, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
